// File: rtl/joypad_responder_if.sv
// Pad-side bus of the NES joypad responder: host lines, local buttons, status.
interface joypad_responder_if;
   logic [7:0] buttons_in;
   logic       jp_latch_in;
   logic       jp_clk_in;
   logic       jp_data_out;
   logic       turbo_a_in;
   logic       turbo_b_in;
   logic       poll_strobe;
   logic [3:0] shift_count;

   // Host/stimulus side: drives the pad inputs and observes the serial line.
   modport master (
      output buttons_in, jp_latch_in, jp_clk_in, turbo_a_in, turbo_b_in,
      input  jp_data_out, poll_strobe, shift_count
   );

   // Responder side.
   modport slave (
      input  buttons_in, jp_latch_in, jp_clk_in, turbo_a_in, turbo_b_in,
      output jp_data_out, poll_strobe, shift_count
   );
endinterface

// File: rtl/joypad_responder.sv
// Controller-side end of the NES serial joypad link (4021-style shift register).
// Host latch/clock are synchronised, glitch-filtered and edge-detected on clk_in.
// Optional turbo on A/B is enabled by defining JOYPAD_TURBO_EN.
module joypad_responder #(
   parameter logic        LATCH_INVERT  = 1'b0,
   parameter int unsigned FILTER_CYCLES = 2,
   parameter int unsigned TURBO_PERIOD  = 4
) (
   input logic             clk_in,
   input logic             rst_in,
   joypad_responder_if.slave jp
);
   localparam int unsigned FILT_W   = (FILTER_CYCLES < 1) ? 1 : $clog2(FILTER_CYCLES + 1);
   localparam int unsigned SHIFT_W  = 8;
   localparam int unsigned COUNT_W  = 4;
   // Bit 1 = host clock (idles high), bit 0 = internal latch (idles low).
   localparam logic [1:0]  IDLE_LVL = 2'b10;

   logic [1:0]         pin;
   logic [1:0]         sync1;
   logic [1:0]         sync2;
   logic [1:0]         filt;
   logic [1:0]         filt_d;
   logic [FILT_W-1:0]  fcnt [2];

   logic               latch_lvl;
   logic               latch_fall;
   logic               clk_rise;
   logic [SHIFT_W-1:0] eff_buttons;

   logic [SHIFT_W-1:0] shift_reg, shift_reg_n;
   logic [COUNT_W-1:0] count, count_n;
   logic               data, data_n;
   logic               strobe, strobe_n;

   assign pin = {jp.jp_clk_in, jp.jp_latch_in ^ LATCH_INVERT};

   // Two-flop synchronisers for the asynchronous host lines.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync1 <= IDLE_LVL;
         sync2 <= IDLE_LVL;
      end else begin
         sync1 <= pin;
         sync2 <= sync1;
      end
   end

   // Level filter: accept a new level after FILTER_CYCLES+1 consecutive differing samples.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         filt    <= IDLE_LVL;
         fcnt[0] <= '0;
         fcnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FILT_W'(FILTER_CYCLES)) begin
               filt[i] <= sync2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + FILT_W'(1);
            end
         end
      end
   end

   // Previous filtered level for edge detection.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) filt_d <= IDLE_LVL;
      else        filt_d <= filt;
   end

   assign latch_lvl  = filt[0];
   assign latch_fall = ~filt[0] & filt_d[0];
   assign clk_rise   = filt[1] & ~filt_d[1];

`ifdef JOYPAD_TURBO_EN
   localparam int unsigned TURBO_W = (TURBO_PERIOD < 2) ? 1 : $clog2(TURBO_PERIOD);

   logic [TURBO_W-1:0] turbo_cnt;
   logic               turbo_phase;

   // Turbo phase flips every TURBO_PERIOD accepted polls.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         turbo_cnt   <= '0;
         turbo_phase <= 1'b0;
      end else if (latch_fall) begin
         if (turbo_cnt == TURBO_W'(TURBO_PERIOD - 1)) begin
            turbo_cnt   <= '0;
            turbo_phase <= ~turbo_phase;
         end else begin
            turbo_cnt <= turbo_cnt + TURBO_W'(1);
         end
      end
   end

   assign eff_buttons = {jp.buttons_in[7:2],
                         jp.buttons_in[1] | (jp.turbo_b_in & turbo_phase),
                         jp.buttons_in[0] | (jp.turbo_a_in & turbo_phase)};
`else
   logic unused_turbo;
   assign unused_turbo = jp.turbo_a_in ^ jp.turbo_b_in;
   assign eff_buttons  = jp.buttons_in;
`endif

   // Shift register, count, data line and poll strobe state.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         shift_reg <= '1;
         count     <= '0;
         data      <= 1'b1;
         strobe    <= 1'b0;
      end else begin
         shift_reg <= shift_reg_n;
         count     <= count_n;
         data      <= data_n;
         strobe    <= strobe_n;
      end
   end

   // Next state: parallel load dominates while latched, otherwise shift zeros in on clock rise.
   always_comb begin
      shift_reg_n = shift_reg;
      count_n     = count;
      data_n      = data;
      strobe_n    = latch_fall;
      if (latch_lvl) begin
         shift_reg_n = ~eff_buttons;
         count_n     = '0;
         data_n      = ~eff_buttons[0];
      end else if (clk_rise) begin
         shift_reg_n = {1'b0, shift_reg[SHIFT_W-1:1]};
         count_n     = (count == COUNT_W'(8)) ? count : count + COUNT_W'(1);
         data_n      = shift_reg_n[0];
      end
   end

   assign jp.jp_data_out = data;
   assign jp.poll_strobe = strobe;
   assign jp.shift_count = count;
endmodule
